axis_rr_arbiter: RTL and testbench
==================================

Name: axis_rr_arbiter

Overview:
Round-robin arbiter that shares one downstream AXI stream sink among NUM_CH AXI stream sources, typically the outputs of several push-to-axis FIFOs. It grants one channel at a time and holds the grant until the packet ends (ilast) or MAX_BURST beats have passed. Output is fully registered and tagged with the source channel number.

Parameters:
NUM_CH, 4, number of input channels (2..16, need not be a power of 2)
WIDTH, 8, data width per channel
CHAN_BITS, 2, width of ochan; must satisfy (1<<CHAN_BITS) >= NUM_CH
MAX_BURST, 16, maximum beats per grant before forced re-arbitration (1..256)

Ports:
wclock  in  1  clock; all logic on its rising edge
resetn  in  1  reset, asynchronous, active-low
idata  in  NUM_CH*WIDTH  channel c data at bits [c*WIDTH +: WIDTH]
ilast  in  NUM_CH  per-channel end-of-packet marker
ivalid  in  NUM_CH  per-channel valid
iready  out  NUM_CH  per-channel ready (combinational)
odata  out  WIDTH  registered output data
ochan  out  CHAN_BITS  registered source channel of odata
olast  out  1  registered copy of ilast for the beat
ovalid  out  1  registered output valid
oready  in  1  downstream ready
busy  out  1  registered; high while state is ACTIVE

Behaviour:
- Reset values: ovalid=0, odata=0, ochan=0, olast=0, busy=0, state=IDLE, grant=0, pointer=0, beat count=0. Reset mid-operation discards any in-flight beat.
- State machine: IDLE, ACTIVE.
- IDLE: if any ivalid bit is set, select the first channel c with ivalid[c]=1, searching pointer, pointer+1, ..., wrapping NUM_CH-1 -> 0. Register grant=c, clear the beat count, go to ACTIVE. All iready bits are 0 in IDLE.
- ACTIVE: iready[grant] = (!ovalid || oready). All other iready bits are 0. A beat transfers when iready[grant] && ivalid[grant]. On transfer, odata/ochan/olast capture idata[grant], grant, ilast[grant]; ovalid=1; beat count increments.
- ovalid update: ovalid <= transfer || (ovalid && !oready). Output data is held while ovalid && !oready.
- Burst end: a transfer with ilast=1, or a transfer that makes the beat count equal MAX_BURST. State goes to IDLE and pointer <= (grant+1) mod NUM_CH, wrapping correctly when NUM_CH is not a power of 2.
- A forced end (MAX_BURST reached) does not assert olast. The packet resumes on a later grant, and ochan lets the sink demultiplex.
- Deasserting ivalid[grant] while ACTIVE keeps the grant; the arbiter waits and no timeout applies.
- Latency: ivalid rises at cycle t in IDLE; grant registered at t+1; first transfer at t+1; ovalid at t+2. There is one idle arbitration cycle between bursts.
- Back-to-back throughput is 1 beat/cycle within a burst when oready is held high.
- Changes to ivalid on non-granted channels never affect the current burst.
- busy equals (state==ACTIVE), registered.
- Beat counter width is enough to count to MAX_BURST. There is no wrap, because it is cleared on each grant.

Test Plan:
- Single channel: reset, ch2 sends 3 beats 0x11,0x22,0x33 with last on 0x33, oready=1 -> odata sequence 0x11,0x22,0x33 with ochan=2, olast only on 0x33, first ovalid 2 cycles after ivalid; then IDLE and pointer=3.
- Round robin: all 4 channels valid with 1-beat packets -> grant order 0,1,2,3,0; each beat separated by one IDLE cycle.
- Forced burst: MAX_BURST=4, ch1 streams 10 beats, last on beat 10, ch3 also valid -> ch1 beats 1-4 (olast=0), ch3 packet, ch1 beats 5-8, ch3, ch1 beats 9-10 with olast on beat 10.
- Backpressure: oready=0 for 5 cycles mid-burst -> odata/ochan/olast stable, iready[grant]=0 after the register fills, no beat lost or duplicated; the stream resumes in order.
- Wrap with NUM_CH=3, CHAN_BITS=2: grant ch2 then ch0 valid -> pointer wraps to 0 and ch0 is granted next.
- Reset mid-burst: assert resetn=0 during ACTIVE with ovalid=1 -> ovalid=0, busy=0, all iready=0 immediately. After release, arbitration restarts from ch0.

Source files
------------

// File: rtl/axis_rr_arbiter_if.sv
// axis_rr_arbiter_if: per-channel AXI stream inputs plus the shared registered output stream
interface axis_rr_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH = 8,
    parameter int CHAN_BITS = 2
);
    logic [NUM_CH*WIDTH-1:0] idata;
    logic [NUM_CH-1:0]       ilast;
    logic [NUM_CH-1:0]       ivalid;
    logic [NUM_CH-1:0]       iready;
    logic [WIDTH-1:0]        odata;
    logic [CHAN_BITS-1:0]    ochan;
    logic                    olast;
    logic                    ovalid;
    logic                    oready;
    modport master (output idata, ilast, ivalid, oready, input iready, odata, ochan, olast, ovalid);
    modport slave  (input idata, ilast, ivalid, oready, output iready, odata, ochan, olast, ovalid);
endinterface

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: round-robin share of one AXI stream sink, grant held to ilast or MAX_BURST beats
module axis_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int WIDTH = 8,
    parameter int CHAN_BITS = 2,
    parameter int MAX_BURST = 16
) (
    input  logic wclock,
    input  logic resetn,
    axis_rr_arbiter_if.slave bus,
    output logic busy
);
    localparam int CW = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, next_state;
    logic [CHAN_BITS-1:0] grant, ptr, sel, ochan;
    logic [CW-1:0] cnt;
    logic [NUM_CH-1:0] gmask, iready;
    logic [WIDTH-1:0] odata;
    logic olast, ovalid, xfer, last_beat;
    int idx;
    assign gmask = NUM_CH'(1) << grant;
    assign xfer = |(iready & bus.ivalid);
    assign last_beat = xfer && (|(bus.ilast & gmask) || cnt == CW'(MAX_BURST - 1));
    // first requesting channel at or after ptr, wrapping at NUM_CH
    always_comb begin
        idx = 0;
        sel = ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            idx = idx >= NUM_CH ? idx - NUM_CH : idx;
            if (|(bus.ivalid & (NUM_CH'(1) << idx))) sel = CHAN_BITS'(idx);
        end
    end
    always_ff @(posedge wclock or negedge resetn)
        if (!resetn) state <= IDLE;
        else state <= next_state;
    always_comb
        next_state = state == IDLE ? (|bus.ivalid ? ACTIVE : IDLE) : (last_beat ? IDLE : ACTIVE);
    always_comb
        iready = (state == ACTIVE && (!ovalid || bus.oready)) ? gmask : '0;
    always_ff @(posedge wclock or negedge resetn) begin
        if (!resetn) begin
            grant  <= '0;
            ptr    <= '0;
            cnt    <= '0;
            odata  <= '0;
            ochan  <= '0;
            olast  <= 1'b0;
            ovalid <= 1'b0;
        end else begin
            if (state == IDLE && |bus.ivalid) begin
                grant <= sel;
                cnt   <= '0;
            end
            if (xfer) begin
                odata <= WIDTH'(bus.idata >> (int'(grant) * WIDTH));
                ochan <= grant;
                olast <= |(bus.ilast & gmask);
                cnt   <= cnt + 1'b1;
            end
            if (last_beat) ptr <= int'(grant) == NUM_CH - 1 ? '0 : grant + 1'b1;
            ovalid <= xfer || (ovalid && !bus.oready);
        end
    end
    assign bus.iready = iready;
    assign bus.odata  = odata;
    assign bus.ochan  = ochan;
    assign bus.olast  = olast;
    assign bus.ovalid = ovalid;
    assign busy = state == ACTIVE;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed checks on three arbiter configurations sharing one clock and reset
module tb_axis_rr_arbiter;
    logic wclock = 1'b0;
    logic resetn = 1'b0;
    logic a_busy, b_busy, c_busy;
    int n_assert = 0;
    int n_fail = 0;
    int i1, i3, k;
    logic x1, x3;
    int exp_c [12] = '{1, 1, 1, 1, 3, 1, 1, 1, 1, 3, 1, 1};
    int exp_d [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hC0, 8'h05, 8'h06, 8'h07, 8'h08, 8'hC1, 8'h09, 8'h0A};
    int exp_l [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1};

    axis_rr_arbiter_if #(.NUM_CH(4), .WIDTH(8), .CHAN_BITS(2)) a_if ();
    axis_rr_arbiter_if #(.NUM_CH(4), .WIDTH(8), .CHAN_BITS(2)) b_if ();
    axis_rr_arbiter_if #(.NUM_CH(3), .WIDTH(8), .CHAN_BITS(2)) c_if ();

    axis_rr_arbiter #(.NUM_CH(4), .WIDTH(8), .CHAN_BITS(2), .MAX_BURST(16)) u_a (
        .wclock(wclock), .resetn(resetn), .bus(a_if.slave), .busy(a_busy));
    axis_rr_arbiter #(.NUM_CH(4), .WIDTH(8), .CHAN_BITS(2), .MAX_BURST(4)) u_b (
        .wclock(wclock), .resetn(resetn), .bus(b_if.slave), .busy(b_busy));
    axis_rr_arbiter #(.NUM_CH(3), .WIDTH(8), .CHAN_BITS(2), .MAX_BURST(16)) u_c (
        .wclock(wclock), .resetn(resetn), .bus(c_if.slave), .busy(c_busy));

    always #5 wclock = ~wclock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge wclock);
        #1;
    endtask

    initial begin
        a_if.idata = '0; a_if.ilast = '0; a_if.ivalid = '0; a_if.oready = 1'b1;
        b_if.idata = '0; b_if.ilast = '0; b_if.ivalid = '0; b_if.oready = 1'b1;
        c_if.idata = '0; c_if.ilast = '0; c_if.ivalid = '0; c_if.oready = 1'b1;
        repeat (2) step;
        chk("rst_ovalid", a_if.ovalid, 0);
        chk("rst_odata", a_if.odata, 0);
        chk("rst_ochan", a_if.ochan, 0);
        chk("rst_olast", a_if.olast, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_iready", a_if.iready, 0);
        resetn = 1'b1;
        step;

        // single channel: ch2 sends 0x11,0x22,0x33
        a_if.ivalid = 4'b0100;
        a_if.idata[23:16] = 8'h11;
        step;
        chk("s_busy", a_busy, 1);
        chk("s_ovalid_t1", a_if.ovalid, 0);
        chk("s_iready", a_if.iready, 4'b0100);
        step;
        chk("s_ovalid_t2", a_if.ovalid, 1);
        chk("s_odata0", a_if.odata, 8'h11);
        chk("s_ochan0", a_if.ochan, 2);
        chk("s_olast0", a_if.olast, 0);
        a_if.idata[23:16] = 8'h22;
        step;
        chk("s_odata1", a_if.odata, 8'h22);
        chk("s_olast1", a_if.olast, 0);
        a_if.idata[23:16] = 8'h33;
        a_if.ilast = 4'b0100;
        step;
        chk("s_odata2", a_if.odata, 8'h33);
        chk("s_ochan2", a_if.ochan, 2);
        chk("s_olast2", a_if.olast, 1);
        chk("s_idle", a_busy, 0);
        chk("s_ptr", u_a.ptr, 3);
        a_if.ivalid = '0;
        a_if.ilast = '0;
        step;
        chk("s_drain", a_if.ovalid, 0);

        resetn = 1'b0;
        step;
        resetn = 1'b1;
        step;

        // round robin with 1-beat packets on every channel
        a_if.ivalid = 4'hF;
        a_if.ilast = 4'hF;
        a_if.idata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int i = 0; i < 5; i++) begin
            step;
            chk("rr_gap", a_if.ovalid, 0);
            step;
            chk("rr_ovalid", a_if.ovalid, 1);
            chk("rr_ochan", a_if.ochan, i % 4);
            chk("rr_odata", a_if.odata, 8'hA0 + i % 4);
            chk("rr_olast", a_if.olast, 1);
        end
        a_if.ivalid = '0;
        a_if.ilast = '0;
        step;
        chk("rr_drain", a_if.ovalid, 0);

        // backpressure mid-burst on ch1
        a_if.ivalid = 4'b0010;
        a_if.idata[15:8] = 8'h51;
        step;
        step;
        chk("bp_odata1", a_if.odata, 8'h51);
        a_if.idata[15:8] = 8'h52;
        step;
        chk("bp_odata2", a_if.odata, 8'h52);
        a_if.oready = 1'b0;
        a_if.idata[15:8] = 8'h53;
        #1;
        chk("bp_iready_full", a_if.iready, 0);
        for (int i = 0; i < 5; i++) begin
            step;
            chk("bp_hold_ovalid", a_if.ovalid, 1);
            chk("bp_hold_odata", a_if.odata, 8'h52);
            chk("bp_hold_ochan", a_if.ochan, 1);
            chk("bp_hold_iready", a_if.iready, 0);
        end
        a_if.oready = 1'b1;
        for (int b = 3; b <= 6; b++) begin
            step;
            chk("bp_odata", a_if.odata, 8'h50 + b);
            chk("bp_olast", a_if.olast, b == 6);
            a_if.idata[15:8] = 8'(8'h51 + b);
            a_if.ilast[1] = (b + 1 == 6);
        end
        a_if.ivalid = '0;
        a_if.ilast = '0;
        step;
        chk("bp_drain", a_if.ovalid, 0);

        // forced burst end with MAX_BURST=4: ch1 10-beat packet against ch3 1-beat packets
        i1 = 0;
        i3 = 0;
        k = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            b_if.ivalid[1] = i1 < 10;
            b_if.idata[15:8] = 8'(i1 + 1);
            b_if.ilast[1] = i1 == 9;
            b_if.ivalid[3] = i3 < 2;
            b_if.idata[31:24] = 8'(192 + i3);
            b_if.ilast[3] = 1'b1;
            #1;
            x1 = b_if.iready[1] && b_if.ivalid[1];
            x3 = b_if.iready[3] && b_if.ivalid[3];
            step;
            if (b_if.ovalid) begin
                if (k < 12) begin
                    chk("fb_ochan", b_if.ochan, exp_c[k]);
                    chk("fb_odata", b_if.odata, exp_d[k]);
                    chk("fb_olast", b_if.olast, exp_l[k]);
                end
                k++;
            end
            if (x1) i1++;
            if (x3) i3++;
        end
        chk("fb_count", k, 12);

        // pointer wrap with NUM_CH=3
        c_if.ivalid = 3'b100;
        c_if.ilast = 3'b111;
        c_if.idata = {8'h92, 8'h91, 8'h90};
        step;
        step;
        chk("wr_ochan2", c_if.ochan, 2);
        chk("wr_odata2", c_if.odata, 8'h92);
        chk("wr_ptr", u_c.ptr, 0);
        c_if.ivalid = 3'b011;
        step;
        step;
        chk("wr_ochan0", c_if.ochan, 0);
        chk("wr_odata0", c_if.odata, 8'h90);
        c_if.ivalid = '0;

        // reset during an active burst
        a_if.ivalid = 4'b1000;
        a_if.idata[31:24] = 8'h77;
        step;
        step;
        chk("mr_pre_ovalid", a_if.ovalid, 1);
        chk("mr_pre_ochan", a_if.ochan, 3);
        resetn = 1'b0;
        #1;
        chk("mr_ovalid", a_if.ovalid, 0);
        chk("mr_busy", a_busy, 0);
        chk("mr_iready", a_if.iready, 0);
        step;
        resetn = 1'b1;
        a_if.ivalid = 4'b1001;
        a_if.ilast = 4'b0001;
        a_if.idata[7:0] = 8'h66;
        step;
        step;
        chk("mr_ochan", a_if.ochan, 0);
        chk("mr_odata", a_if.odata, 8'h66);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
